// File: rtl/alarme_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarme_pkg
// Description : Shared types and constants for the alarme_ctrl slice:
//               FSM state codes, trip counter width/saturation value and a
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alarme_pkg;

  // FSM state codes; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PENDING  = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

  // Trip counter: 8 bits, sticks at all-ones.
  localparam int                TRIP_W   = 8;
  localparam logic [TRIP_W-1:0] TRIP_MAX = 8'd255;

  // Bits needed to hold any value 0..max_val, never less than one bit so
  // degenerate parameter choices still produce a legal vector.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarme.sv
`default_nettype none
// ============================================================================
// Module      : alarme
// Description : Combinational 2-of-3 majority voter for buttons A, B, C.
// Revision    : 1.0 - initial release
// ============================================================================
module alarme (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Y
);

  // Y is high whenever at least two of the three buttons are pressed.
  assign Y = (A & B) | (A & C) | (B & C);

endmodule
`default_nettype wire

// File: rtl/alarme_debounce.sv
`default_nettype none
// ============================================================================
// Module      : alarme_debounce
// Description : Registers the raw buttons once, votes them with the majority
//               voter and qualifies the vote with a saturating run counter.
//               trip_o pulses once per continuous majority episode, on the
//               cycle the run reaches DEBOUNCE_CYCLES samples.
// Revision    : 1.0 - initial release
// ============================================================================
module alarme_debounce
  import alarme_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic maj_o,
  output logic trip_o
);

  localparam int               DBC_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DBC_W-1:0] DBC_MAX  = DBC_W'(DEBOUNCE_CYCLES);
  localparam logic [DBC_W-1:0] DBC_TRIP = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

  logic             a_q;
  logic             b_q;
  logic             c_q;
  logic             maj_q;
  logic [DBC_W-1:0] dbc_q;
  logic [DBC_W-1:0] dbc_d;

  // Vote on the registered buttons so the counter sees one clean sample per cycle.
  alarme u_voter (
    .A (a_q),
    .B (b_q),
    .C (c_q),
    .Y (maj_q)
  );

  // Run counter: restart on any gap in the majority, stick at the maximum.
  always_comb begin
    dbc_d = dbc_q;
    if (!maj_q) begin
      dbc_d = '0;
    end else if (dbc_q < DBC_MAX) begin
      dbc_d = dbc_q + DBC_ONE;
    end
  end

  // Input sampling stage and run counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      c_q   <= 1'b0;
      dbc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      c_q   <= c_i;
      dbc_q <= dbc_d;
    end
  end

  // The counter saturates past DBC_TRIP, so this fires once per episode.
  assign trip_o = maj_q & (dbc_q == DBC_TRIP);
  assign maj_o  = maj_q;

endmodule
`default_nettype wire

// File: rtl/alarme_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarme_ctrl
// Description : Arm/disarm alarm controller. A debounced majority trip moves
//               ARMED to PENDING; after the entry delay the siren runs in
//               ALARM for whole siren periods while the majority persists.
//               Y, armed, state and trip_count are all registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alarme_ctrl
  import alarme_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ENTRY_DELAY     = 8,
  parameter int SIREN_CYCLES    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              A,
  input  logic              B,
  input  logic              C,
  input  logic              arm,
  input  logic              disarm,
  output logic              Y,
  output logic              armed,
  output logic [1:0]        state,
  output logic [TRIP_W-1:0] trip_count
);

  localparam int               DLY_W    = cnt_w(ENTRY_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ENTRY_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam int               SIR_W    = cnt_w(SIREN_CYCLES - 1);
  localparam logic [SIR_W-1:0] SIR_LOAD = SIR_W'(SIREN_CYCLES - 1);
  localparam logic [SIR_W-1:0] SIR_ONE  = SIR_W'(1);
  localparam logic [TRIP_W-1:0] TRIP_ONE = TRIP_W'(1);

  logic              maj;
  logic              trip;

  state_e            state_q;
  state_e            state_d;
  logic [DLY_W-1:0]  dly_q;
  logic [DLY_W-1:0]  dly_d;
  logic [SIR_W-1:0]  sir_q;
  logic [SIR_W-1:0]  sir_d;
  logic [TRIP_W-1:0] trip_cnt_q;
  logic [TRIP_W-1:0] trip_cnt_d;
  logic              y_q;
  logic              y_d;
  logic              armed_q;
  logic              armed_d;

  alarme_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .a_i    (A),
    .b_i    (B),
    .c_i    (C),
    .maj_o  (maj),
    .trip_o (trip)
  );

  // State, timers, trip counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DISARMED;
      dly_q      <= '0;
      sir_q      <= '0;
      trip_cnt_q <= '0;
      y_q        <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      sir_q      <= sir_d;
      trip_cnt_q <= trip_cnt_d;
      y_q        <= y_d;
      armed_q    <= armed_d;
    end
  end

  // Next state and timer updates; disarm beats every other request.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    sir_d      = sir_q;
    trip_cnt_d = trip_cnt_q;
    if (disarm) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trip) begin
            state_d = ST_PENDING;
            dly_d   = DLY_LOAD;
          end
        end
        ST_PENDING: begin
          // Further majority episodes here are deliberately ignored.
          if (dly_q == '0) begin
            state_d = ST_ALARM;
            sir_d   = SIR_LOAD;
            if (trip_cnt_q != TRIP_MAX) begin
              trip_cnt_d = trip_cnt_q + TRIP_ONE;
            end
          end else begin
            dly_d = dly_q - DLY_ONE;
          end
        end
        ST_ALARM: begin
          // At the end of each siren period, keep sounding only while the
          // majority is still present; arm has no effect here.
          if (sir_q == '0) begin
            if (maj) begin
              sir_d = SIR_LOAD;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            sir_d = sir_q - SIR_ONE;
          end
        end
        default: begin
          state_d = ST_DISARMED;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they change on the same edge as state.
  always_comb begin
    y_d     = (state_d == ST_ALARM);
    armed_d = (state_d != ST_DISARMED);
  end

  assign Y          = y_q;
  assign armed      = armed_q;
  assign state      = state_q;
  assign trip_count = trip_cnt_q;

endmodule
`default_nettype wire
